// File: rtl/hazard_ctrl_pkg.sv
// Shared pipeline definitions for the 5-stage MIPS core: the hazard-controller
// state encodings, the register-index width, the nop encoding and the
// load-use detection helper.
package hazard_ctrl_pkg;

    localparam int          REG_W = 5;
    localparam logic [31:0] NOP   = 32'h0;

    typedef enum logic [1:0] {
        BOOT       = 2'd0,
        RUN        = 2'd1,
        REDIR_PEND = 2'd2
    } hz_state_t;

    // A load in EX whose destination is a real register and is read by the
    // instruction in ID. rt only matters when the ID instruction reads it.
    function automatic logic load_use_hit(
        input logic             mem_read,
        input logic [REG_W-1:0] ex_rt,
        input logic [REG_W-1:0] id_rs,
        input logic [REG_W-1:0] id_rt,
        input logic             uses_rt
    );
        return mem_read && (ex_rt != '0) &&
               ((ex_rt == id_rs) || (uses_rt && (ex_rt == id_rt)));
    endfunction

endpackage

// File: rtl/hazard_ctrl_if.sv
// Hazard-control bundle between the pipeline datapath and hazard_ctrl.
// master: the hazard controller; slave: the pipeline registers and PC logic.
interface hazard_ctrl_if #(
    parameter int PERF_W = 32
);
    import hazard_ctrl_pkg::*;

    logic             ID_EX_MemRead;
    logic [REG_W-1:0] ID_EX_RegisterRt;
    logic [REG_W-1:0] IF_ID_RegisterRs;
    logic [REG_W-1:0] IF_ID_RegisterRt;
    logic             IF_ID_UsesRt;
    logic             ID_Jump;
    logic             EX_BranchTaken;
    logic             IMem_Ready;
    logic             DMem_Busy;

    logic              PC_Wr;
    logic              IF_ID_Wr;
    logic              IF_ID_Flush;
    logic              ID_EX_Wr;
    logic              ID_EX_Flush;
    logic              EX_MEM_Wr;
    logic              Redirect_Latch;
    logic              Redirect_Pending;
    logic [PERF_W-1:0] Stall_Count;
    logic [PERF_W-1:0] Flush_Count;

    modport master (
        input  ID_EX_MemRead, ID_EX_RegisterRt, IF_ID_RegisterRs, IF_ID_RegisterRt,
               IF_ID_UsesRt, ID_Jump, EX_BranchTaken, IMem_Ready, DMem_Busy,
        output PC_Wr, IF_ID_Wr, IF_ID_Flush, ID_EX_Wr, ID_EX_Flush, EX_MEM_Wr,
               Redirect_Latch, Redirect_Pending, Stall_Count, Flush_Count
    );

    modport slave (
        output ID_EX_MemRead, ID_EX_RegisterRt, IF_ID_RegisterRs, IF_ID_RegisterRt,
               IF_ID_UsesRt, ID_Jump, EX_BranchTaken, IMem_Ready, DMem_Busy,
        input  PC_Wr, IF_ID_Wr, IF_ID_Flush, ID_EX_Wr, ID_EX_Flush, EX_MEM_Wr,
               Redirect_Latch, Redirect_Pending, Stall_Count, Flush_Count
    );

endinterface

// File: rtl/hazard_perf_cnt.sv
// Saturating event counter: counts cycles with inc high, sticks at all-ones.
module hazard_perf_cnt #(
    parameter int PERF_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              inc,
    output logic [PERF_W-1:0] count
);

    // Count qualified events, holding once the counter is full.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            count <= '0;
        else if (inc && (count != {PERF_W{1'b1}}))
            count <= count + PERF_W'(1);
    end

endmodule

// File: rtl/hazard_ctrl.sv
// Central pipeline-control unit of the 5-stage MIPS core: load-use stalls,
// jump/branch redirects, fetch wait states, data-memory freezes, a redirect
// held across fetch waits, and a post-reset pipeline purge.
// Optional macro HAZ_PERF_EN adds saturating stall/flush performance counters;
// without it Stall_Count and Flush_Count are constant zero.
module hazard_ctrl
    import hazard_ctrl_pkg::*;
#(
    parameter int BOOT_CYCLES = 3,
    parameter int PERF_W      = 32
) (
    input  logic         clk,
    input  logic         reset,
    hazard_ctrl_if.master hz
);

    hz_state_t  state, next_state;
    logic [3:0] boot_cnt;

    logic pc_wr, if_id_wr, if_id_flush, id_ex_wr, id_ex_flush, ex_mem_wr;
    logic redir_latch, redir_pend;
    logic load_use;

    assign load_use = load_use_hit(hz.ID_EX_MemRead, hz.ID_EX_RegisterRt,
                                   hz.IF_ID_RegisterRs, hz.IF_ID_RegisterRt,
                                   hz.IF_ID_UsesRt);

    // State register; reset abandons any pending redirect and restarts the purge.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            state <= BOOT;
        else
            state <= next_state;
    end

    // Boot purge length counter, decremented only while purging.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            boot_cnt <= 4'(BOOT_CYCLES - 1);
        else if ((state == BOOT) && (boot_cnt != 4'd0))
            boot_cnt <= boot_cnt - 4'd1;
    end

    // Next state and control outputs; rules in RUN are checked in priority order.
    always_comb begin
        next_state  = state;
        pc_wr       = 1'b1;
        if_id_wr    = 1'b1;
        if_id_flush = 1'b0;
        id_ex_wr    = 1'b1;
        id_ex_flush = 1'b0;
        ex_mem_wr   = 1'b1;
        redir_latch = 1'b0;
        redir_pend  = 1'b0;
        case (state)
            BOOT: begin
                pc_wr       = 1'b0;
                if_id_wr    = 1'b0;
                if_id_flush = 1'b1;
                id_ex_flush = 1'b1;
                if (boot_cnt == 4'd0)
                    next_state = RUN;
            end
            RUN: begin
                if (hz.DMem_Busy) begin
                    // Full freeze; a taken branch stays in EX and is seen later.
                    pc_wr     = 1'b0;
                    if_id_wr  = 1'b0;
                    id_ex_wr  = 1'b0;
                    ex_mem_wr = 1'b0;
                end else if (hz.EX_BranchTaken) begin
                    if_id_flush = 1'b1;
                    id_ex_flush = 1'b1;
                    if (!hz.IMem_Ready) begin
                        pc_wr       = 1'b0;
                        redir_latch = 1'b1;
                        next_state  = REDIR_PEND;
                    end
                end else if (load_use) begin
                    pc_wr       = 1'b0;
                    if_id_wr    = 1'b0;
                    id_ex_flush = 1'b1;
                end else if (hz.ID_Jump) begin
                    if_id_flush = 1'b1;
                    if (!hz.IMem_Ready) begin
                        pc_wr       = 1'b0;
                        redir_latch = 1'b1;
                        next_state  = REDIR_PEND;
                    end
                end else if (!hz.IMem_Ready) begin
                    pc_wr       = 1'b0;
                    if_id_wr    = 1'b0;
                    if_id_flush = 1'b1;
                end
            end
            REDIR_PEND: begin
                redir_pend = 1'b1;
                if (hz.DMem_Busy) begin
                    pc_wr     = 1'b0;
                    if_id_wr  = 1'b0;
                    id_ex_wr  = 1'b0;
                    ex_mem_wr = 1'b0;
                end else begin
                    if_id_flush = 1'b1;
                    if_id_wr    = 1'b0;
                    pc_wr       = hz.IMem_Ready;
                    if (hz.IMem_Ready)
                        next_state = RUN;
                end
            end
            default: next_state = BOOT;
        endcase
        if (!reset) begin
            pc_wr       = 1'b0;
            if_id_wr    = 1'b0;
            if_id_flush = 1'b1;
            id_ex_wr    = 1'b0;
            id_ex_flush = 1'b1;
            ex_mem_wr   = 1'b0;
            redir_latch = 1'b0;
            redir_pend  = 1'b0;
        end
    end

    assign hz.PC_Wr            = pc_wr;
    assign hz.IF_ID_Wr         = if_id_wr;
    assign hz.IF_ID_Flush      = if_id_flush;
    assign hz.ID_EX_Wr         = id_ex_wr;
    assign hz.ID_EX_Flush      = id_ex_flush;
    assign hz.EX_MEM_Wr        = ex_mem_wr;
    assign hz.Redirect_Latch   = redir_latch;
    assign hz.Redirect_Pending = redir_pend;

`ifdef HAZ_PERF_EN
    logic stall_inc, flush_inc;

    assign stall_inc = (state != BOOT) && !pc_wr;
    assign flush_inc = (state != BOOT) && (if_id_flush || id_ex_flush);

    hazard_perf_cnt #(.PERF_W(PERF_W)) u_stall_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (stall_inc),
        .count (hz.Stall_Count)
    );

    hazard_perf_cnt #(.PERF_W(PERF_W)) u_flush_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (flush_inc),
        .count (hz.Flush_Count)
    );
`else
    assign hz.Stall_Count = {PERF_W{1'b0}};
    assign hz.Flush_Count = {PERF_W{1'b0}};
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl. Inputs change on the falling edge and the
// combinational controls are sampled 1 ns later, well away from the rising edge.
// Control vector bit order:
// {PC_Wr, IF_ID_Wr, IF_ID_Flush, ID_EX_Wr, ID_EX_Flush, EX_MEM_Wr, Redirect_Latch, Redirect_Pending}
module tb_hazard_ctrl;

    localparam int PW = 32;

    localparam logic [7:0] C_RST         = 8'b0010_1000;
    localparam logic [7:0] C_BOOT        = 8'b0011_1100;
    localparam logic [7:0] C_RUN         = 8'b1101_0100;
    localparam logic [7:0] C_LOADUSE     = 8'b0001_1100;
    localparam logic [7:0] C_BRANCH_RDY  = 8'b1111_1100;
    localparam logic [7:0] C_BRANCH_NRDY = 8'b0111_1110;
    localparam logic [7:0] C_JUMP_RDY    = 8'b1111_0100;
    localparam logic [7:0] C_JUMP_NRDY   = 8'b0111_0110;
    localparam logic [7:0] C_PEND_WAIT   = 8'b0011_0101;
    localparam logic [7:0] C_PEND_RDY    = 8'b1011_0101;
    localparam logic [7:0] C_FREEZE      = 8'b0000_0000;
    localparam logic [7:0] C_PEND_FREEZE = 8'b0000_0001;
    localparam logic [7:0] C_FETCH_WAIT  = 8'b0011_0100;

`ifdef HAZ_PERF_EN
    localparam logic [PW-1:0] EXP_STALL = 4;
    localparam logic [PW-1:0] EXP_FLUSH = 5;
`else
    localparam logic [PW-1:0] EXP_STALL = 0;
    localparam logic [PW-1:0] EXP_FLUSH = 0;
`endif

    logic clk = 1'b0;
    logic reset;
    int   vec = 0;
    int   err = 0;

    always #5 clk = ~clk;

    hazard_ctrl_if #(.PERF_W(PW)) hz ();

    hazard_ctrl #(.BOOT_CYCLES(3), .PERF_W(PW)) dut (
        .clk   (clk),
        .reset (reset),
        .hz    (hz)
    );

    function automatic logic [7:0] ctl();
        return {hz.PC_Wr, hz.IF_ID_Wr, hz.IF_ID_Flush, hz.ID_EX_Wr,
                hz.ID_EX_Flush, hz.EX_MEM_Wr, hz.Redirect_Latch, hz.Redirect_Pending};
    endfunction

    task automatic idle();
        hz.ID_EX_MemRead    = 1'b0;
        hz.ID_EX_RegisterRt = 5'd0;
        hz.IF_ID_RegisterRs = 5'd0;
        hz.IF_ID_RegisterRt = 5'd0;
        hz.IF_ID_UsesRt     = 1'b0;
        hz.ID_Jump          = 1'b0;
        hz.EX_BranchTaken   = 1'b0;
        hz.IMem_Ready       = 1'b1;
        hz.DMem_Busy        = 1'b0;
    endtask

    // While a redirect is pending, ID and EX hold bubbles: no branch, jump or load-use may appear.
    always @(negedge clk) begin
        #2;
        if (reset === 1'b1 && hz.Redirect_Pending === 1'b1) begin
            vec++;
            if (hz.EX_BranchTaken || hz.ID_Jump ||
                (hz.ID_EX_MemRead && hz.ID_EX_RegisterRt != 0 &&
                 hz.ID_EX_RegisterRt == hz.IF_ID_RegisterRs)) begin
                err++;
                $display("FAIL pend_protocol: got branch=%b jump=%b memread=%b required all quiet",
                         hz.EX_BranchTaken, hz.ID_Jump, hz.ID_EX_MemRead);
            end
        end
    end

    task automatic test_reset();
        idle();
        reset = 1'b0;
        for (int i = 0; i < 2; i++) begin
            #1;
            vec++;
            if (ctl() !== C_RST) begin err++; $display("FAIL reset_%0d: got %b required %b", i, ctl(), C_RST); end
            vec++;
            if (hz.Stall_Count !== '0 || hz.Flush_Count !== '0) begin
                err++; $display("FAIL reset_cnt_%0d: got %0d/%0d required 0/0", i, hz.Stall_Count, hz.Flush_Count);
            end
            @(negedge clk);
        end
        reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            vec++;
            if (ctl() !== C_BOOT) begin err++; $display("FAIL boot_%0d: got %b required %b", i, ctl(), C_BOOT); end
            @(negedge clk);
        end
        #1;
        vec++;
        if (ctl() !== C_RUN) begin err++; $display("FAIL boot_done: got %b required %b", ctl(), C_RUN); end
        @(negedge clk);
    endtask

    task automatic test_load_use();
        logic [7:0] exp;
        // {MemRead, ExRt, IdRs, IdRt, UsesRt, expected}
        logic [20:0] tbl [6];
        tbl[0] = {1'b1, 5'd8, 5'd8, 5'd2, 1'b0, 4'h1};
        tbl[1] = {1'b0, 5'd8, 5'd8, 5'd2, 1'b0, 4'h0};
        tbl[2] = {1'b1, 5'd0, 5'd0, 5'd0, 1'b1, 4'h0};
        tbl[3] = {1'b1, 5'd8, 5'd3, 5'd8, 1'b1, 4'h1};
        tbl[4] = {1'b1, 5'd8, 5'd3, 5'd8, 1'b0, 4'h0};
        tbl[5] = {1'b1, 5'd9, 5'd3, 5'd8, 1'b1, 4'h0};
        for (int i = 0; i < 6; i++) begin
            idle();
            hz.ID_EX_MemRead    = tbl[i][20];
            hz.ID_EX_RegisterRt = tbl[i][19:15];
            hz.IF_ID_RegisterRs = tbl[i][14:10];
            hz.IF_ID_RegisterRt = tbl[i][9:5];
            hz.IF_ID_UsesRt     = tbl[i][4];
            exp = tbl[i][0] ? C_LOADUSE : C_RUN;
            #1;
            vec++;
            if (ctl() !== exp) begin err++; $display("FAIL load_use_%0d: got %b required %b", i, ctl(), exp); end
            @(negedge clk);
        end
        idle();
    endtask

    task automatic test_branch();
        idle();
        hz.EX_BranchTaken = 1'b1;
        #1;
        vec++;
        if (ctl() !== C_BRANCH_RDY) begin err++; $display("FAIL branch_rdy: got %b required %b", ctl(), C_BRANCH_RDY); end
        @(negedge clk);
        idle();
        #1;
        vec++;
        if (ctl() !== C_RUN) begin err++; $display("FAIL branch_after: got %b required %b", ctl(), C_RUN); end
        @(negedge clk);
        hz.EX_BranchTaken = 1'b1;
        hz.IMem_Ready     = 1'b0;
        #1;
        vec++;
        if (ctl() !== C_BRANCH_NRDY) begin err++; $display("FAIL branch_nrdy: got %b required %b", ctl(), C_BRANCH_NRDY); end
        @(negedge clk);
        idle();
        #1;
        vec++;
        if (ctl() !== C_PEND_RDY) begin err++; $display("FAIL branch_pend_rdy: got %b required %b", ctl(), C_PEND_RDY); end
        @(negedge clk);
    endtask

    task automatic test_jump_wait();
        idle();
        hz.ID_Jump    = 1'b1;
        hz.IMem_Ready = 1'b0;
        #1;
        vec++;
        if (ctl() !== C_JUMP_NRDY) begin err++; $display("FAIL jump_latch: got %b required %b", ctl(), C_JUMP_NRDY); end
        @(negedge clk);
        hz.ID_Jump = 1'b0;
        for (int i = 0; i < 2; i++) begin
            #1;
            vec++;
            if (ctl() !== C_PEND_WAIT) begin err++; $display("FAIL jump_wait_%0d: got %b required %b", i, ctl(), C_PEND_WAIT); end
            @(negedge clk);
        end
        hz.IMem_Ready = 1'b1;
        #1;
        vec++;
        if (ctl() !== C_PEND_RDY) begin err++; $display("FAIL jump_load: got %b required %b", ctl(), C_PEND_RDY); end
        @(negedge clk);
        #1;
        vec++;
        if (ctl() !== C_RUN) begin err++; $display("FAIL jump_run: got %b required %b", ctl(), C_RUN); end
        @(negedge clk);
        hz.ID_Jump = 1'b1;
        #1;
        vec++;
        if (ctl() !== C_JUMP_RDY) begin err++; $display("FAIL jump_rdy: got %b required %b", ctl(), C_JUMP_RDY); end
        @(negedge clk);
        idle();
    endtask

    task automatic test_freeze();
        idle();
        hz.DMem_Busy      = 1'b1;
        hz.EX_BranchTaken = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            vec++;
            if (ctl() !== C_FREEZE) begin err++; $display("FAIL freeze_%0d: got %b required %b", i, ctl(), C_FREEZE); end
            @(negedge clk);
        end
        hz.DMem_Busy = 1'b0;
        #1;
        vec++;
        if (ctl() !== C_BRANCH_RDY) begin err++; $display("FAIL freeze_release: got %b required %b", ctl(), C_BRANCH_RDY); end
        @(negedge clk);
        idle();
        hz.ID_Jump    = 1'b1;
        hz.IMem_Ready = 1'b0;
        @(negedge clk);
        idle();
        hz.DMem_Busy = 1'b1;
        #1;
        vec++;
        if (ctl() !== C_PEND_FREEZE) begin err++; $display("FAIL pend_freeze: got %b required %b", ctl(), C_PEND_FREEZE); end
        @(negedge clk);
        hz.DMem_Busy = 1'b0;
        #1;
        vec++;
        if (ctl() !== C_PEND_RDY) begin err++; $display("FAIL pend_unfreeze: got %b required %b", ctl(), C_PEND_RDY); end
        @(negedge clk);
        idle();
    endtask

    task automatic test_fetch_priority();
        idle();
        hz.IMem_Ready = 1'b0;
        #1;
        vec++;
        if (ctl() !== C_FETCH_WAIT) begin err++; $display("FAIL fetch_wait: got %b required %b", ctl(), C_FETCH_WAIT); end
        @(negedge clk);
        idle();
        hz.ID_EX_MemRead    = 1'b1;
        hz.ID_EX_RegisterRt = 5'd4;
        hz.IF_ID_RegisterRs = 5'd4;
        hz.ID_Jump          = 1'b1;
        #1;
        vec++;
        if (ctl() !== C_LOADUSE) begin err++; $display("FAIL prio_loaduse_jump: got %b required %b", ctl(), C_LOADUSE); end
        hz.EX_BranchTaken = 1'b1;
        #1;
        vec++;
        if (ctl() !== C_BRANCH_RDY) begin err++; $display("FAIL prio_branch: got %b required %b", ctl(), C_BRANCH_RDY); end
        @(negedge clk);
        idle();
    endtask

    task automatic test_perf_and_reset();
        idle();
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        repeat (3) @(negedge clk);
        hz.ID_EX_MemRead    = 1'b1;
        hz.ID_EX_RegisterRt = 5'd8;
        hz.IF_ID_RegisterRs = 5'd8;
        @(negedge clk);
        idle();
        @(negedge clk);
        hz.ID_Jump    = 1'b1;
        hz.IMem_Ready = 1'b0;
        @(negedge clk);
        hz.ID_Jump = 1'b0;
        repeat (2) @(negedge clk);
        hz.IMem_Ready = 1'b1;
        @(negedge clk);
        #1;
        vec++;
        if (hz.Stall_Count !== EXP_STALL) begin err++; $display("FAIL stall_count: got %0d required %0d", hz.Stall_Count, EXP_STALL); end
        vec++;
        if (hz.Flush_Count !== EXP_FLUSH) begin err++; $display("FAIL flush_count: got %0d required %0d", hz.Flush_Count, EXP_FLUSH); end
        @(negedge clk);
        hz.ID_Jump    = 1'b1;
        hz.IMem_Ready = 1'b0;
        @(negedge clk);
        hz.ID_Jump = 1'b0;
        #1;
        vec++;
        if (ctl() !== C_PEND_WAIT) begin err++; $display("FAIL pend_before_reset: got %b required %b", ctl(), C_PEND_WAIT); end
        reset = 1'b0;
        #1;
        vec++;
        if (ctl() !== C_RST) begin err++; $display("FAIL reset_in_pend: got %b required %b", ctl(), C_RST); end
        vec++;
        if (hz.Stall_Count !== '0 || hz.Flush_Count !== '0) begin
            err++; $display("FAIL reset_in_pend_cnt: got %0d/%0d required 0/0", hz.Stall_Count, hz.Flush_Count);
        end
        @(negedge clk);
        reset = 1'b1;
        hz.IMem_Ready = 1'b1;
        #1;
        vec++;
        if (ctl() !== C_BOOT) begin err++; $display("FAIL reboot: got %b required %b", ctl(), C_BOOT); end
        repeat (3) @(negedge clk);
        #1;
        vec++;
        if (ctl() !== C_RUN) begin err++; $display("FAIL reboot_run: got %b required %b", ctl(), C_RUN); end
        @(negedge clk);
    endtask

    initial begin
        reset = 1'b1;
        idle();
        #2;
        reset = 1'b0;
        @(negedge clk);
        test_reset();
        test_load_use();
        test_branch();
        test_jump_wait();
        test_freeze();
        test_fetch_priority();
        test_perf_and_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vec, err);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL timeout: got no completion required completion by 20000");
        $fatal(1, "timeout");
    end

endmodule
